ed_gaussian_filter_stream: RTL
==============================

Name: ed_gaussian_filter_stream

Overview:
- Parametrised, self-buffering successor to the 3x3 edge-detection smoothing kernel.
- Accepts a raster pixel stream with valid/ready handshaking and holds two line buffers internally.
- Generates the border conditions from its own column and row counters.
- Applies a runtime-selectable smoothing mode and emits a valid-tagged, frame-marked output stream ahead of the edge detector.

Parameters:
- CH_W, 4, bits per colour channel.
- N_CH, 3, number of channels packed in a pixel, MSB channel first (R,G,B).
- IMG_W, 640, pixels per line (>=3).
- IMG_H, 480, lines per frame (>=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- mode_in  in  2  00 bypass, 01 3x3 gaussian, 10 horizontal 1-2-1, 11 treated as 01.
- in_valid  in  1  input pixel present.
- in_ready  out  1  block can accept an input pixel this cycle.
- in_sof  in  1  first pixel of frame; qualified by in_valid&in_ready.
- in_pixel  in  N_CH*CH_W  input pixel.
- out_valid  out  1  out_pixel valid this cycle.
- out_sof  out  1  with out_valid: output pixel (0,0).
- out_eol  out  1  with out_valid: last pixel of an output line.
- out_pixel  out  N_CH*CH_W  filtered pixel.

Behaviour:
- Reset: all outputs 0 except in_ready=1; state IDLE; all counters 0; mode register 01. Line-buffer contents are not reset.
- An input transfer occurs when in_valid&in_ready. in_ready=1 in IDLE and ACTIVE, 0 in FLUSH.
- IDLE:
  - Transfers without in_sof are dropped.
  - A transfer with in_sof latches mode_in into the mode register, writes the pixel as input (0,0), and moves to ACTIVE.
  - The mode is constant for the whole frame.
- ACTIVE:
  - Each transfer advances input col/row. Col wraps at IMG_W-1, and row increments on wrap.
  - The pixel is written into the line buffers, which delay by IMG_W and 2*IMG_W.
  - The 3x3 window shifts by one column per transfer.
  - After the transfer of input (IMG_H-1, IMG_W-1), go to FLUSH.
- FLUSH:
  - Inject exactly IMG_W+1 zero pixels, one per clk, ignoring in_valid, then return to IDLE.
  - Inputs arriving during FLUSH are not accepted.
- Restart on in_sof: a transfer with in_sof while ACTIVE aborts the current frame.
  - Counters clear and pipeline valids clear, so no further outputs from the old frame appear.
  - The mode is relatched and the pixel becomes (0,0) of the new frame.
- Output coordinates:
  - The centre pixel (r,c) is computed when input/injected pixel index r*IMG_W+c+IMG_W+1 enters the window.
  - Separate output col/row counters track (r,c); each output pixel is produced exactly once per frame, IMG_W*IMG_H per frame.
- Border zeroing is applied on output coordinates before weighting:
  - c=0: left column zeroed.
  - c=IMG_W-1: right column zeroed.
  - r=0: top row zeroed.
  - r=IMG_H-1: bottom row zeroed.
  - Stale line-buffer data must never leak through.
- Weights, per channel independently:
  - Mode 01: [1 2 1;2 4 2;1 2 1], sum width CH_W+4, result = sum>>4 (truncate).
  - Mode 10: centre row [1 2 1], result = sum>>2.
  - Mode 00: centre pixel unchanged.
  - No saturation is needed, since the result is never greater than 2^CH_W-1.
- Latency: out_valid for (r,c) is asserted exactly 2 clk after the cycle in which its completing pixel entered the window (window register stage, then sum/output register stage), for all modes.
- out_sof=1 only for (0,0); out_eol=1 only for c=IMG_W-1. Both are 0 whenever out_valid=0.
- out_pixel holds its last value when out_valid=0.
- Gaps: in_valid may deassert on any cycle. The window and counters freeze, and the output sequence is identical to the gapless case apart from timing.
- Back-to-back frames: in_sof may arrive on the first cycle after FLUSH completes (IDLE).
- Reset mid-frame: the next cycle shows out_valid=0, in_ready=1, IDLE.

Test Plan:
Bench uses IMG_W=4, IMG_H=3, CH_W=4, N_CH=3 unless noted.
1. Gaussian, uniform 0xFFF frame, gapless -> 12 outputs:
   - corners 0x888, top/bottom edges 0xBBB, left/right edges (1,0),(1,3) 0xBBB, interior (1,1),(1,2) 0xFFF;
   - out_sof on the first output only, out_eol on every 4th output;
   - in_ready=0 for exactly 5 cycles after the last input.
2. Gaussian impulse, 0xF00 at (1,1), others 0 -> (1,1)=0x300, (0,1)=(1,0)=(1,2)=(2,1)=0x100, all others 0x000.
3. Bypass, ramp pixel k = k*0x111 (k=0..11) -> outputs equal inputs in order, same 2-cycle post-window latency as the gaussian case.
4. Horizontal mode, uniform 0xFFF -> columns 0 and 3 = 0xBBB, columns 1 and 2 = 0xFFF, all rows.
5. Scenario 1 stimulus with random in_valid gaps of 0-3 cycles -> identical out_pixel/out_sof/out_eol sequence.
6. Abort and reset:
   - in_sof at input index 6 -> no outputs from the aborted frame appear after that cycle, and the new frame output matches scenario 1.
   - reset asserted mid-FLUSH -> next cycle out_valid=0, in_ready=1, and a following frame produces correct output.

Source files
------------

// File: rtl/ed_gaussian_filter_stream.sv
// Streaming 3x3 smoothing filter with internal line buffers, self-generated
// border handling and a frame-marked valid-tagged output stream.
module ed_gaussian_filter_stream #(
    parameter int CH_W  = 4,
    parameter int N_CH  = 3,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic [N_CH*CH_W-1:0] in_pixel,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic [N_CH*CH_W-1:0] out_pixel
);

    localparam int PW = N_CH * CH_W;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 1);
    localparam int GW = CH_W + 4;
    localparam int HW = CH_W + 2;

    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [CW-1:0]   inCol_q, inCol_d;
    logic [RW-1:0]   inRow_q, inRow_d;
    logic [CW-1:0]   outCol_q, outCol_d;
    logic [RW-1:0]   outRow_q, outRow_d;
    logic [FW-1:0]   flushCnt_q, flushCnt_d;
    logic [CW-1:0]   lbPtr_q, lbPtr_d;

    logic [PW-1:0]   lineBuf1 [IMG_W];
    logic [PW-1:0]   lineBuf2 [IMG_W];
    logic [PW-1:0]   win_q [3][3];

    logic            v1_q;
    logic [CW-1:0]   c1_q;
    logic [RW-1:0]   r1_q;
    logic [1:0]      mode1_q;

    logic            outValid_q, outValid_d;
    logic            outSof_q, outSof_d;
    logic            outEol_q, outEol_d;
    logic [PW-1:0]   outPixel_q, outPixel_d;

    logic            xfer;
    logic            frameStart;
    logic            abortFrame;
    logic            shift;
    logic            producing;
    logic [PW-1:0]   newPix;

    logic [2:0]      rowOk;
    logic [2:0]      colOk;
    logic [CH_W-1:0] tap [3][3];
    logic [GW-1:0]   gSum;
    logic [HW-1:0]   hSum;
    logic [PW-1:0]   filtPix;

    // A new window column is accepted on every frame-relevant transfer and on every flush cycle.
    // The centre becomes valid once pixel index IMG_W+1 of the frame has entered the window.
    assign in_ready   = (state_q != FLUSH);
    assign xfer       = in_valid && in_ready;
    assign frameStart = xfer && in_sof;
    assign abortFrame = frameStart && (state_q == ACTIVE);
    assign shift      = frameStart || (xfer && (state_q == ACTIVE)) || (state_q == FLUSH);
    assign producing  = shift && !frameStart &&
                        ((state_q == FLUSH) ||
                         ((inRow_q != '0) && !((inRow_q == RW'(1)) && (inCol_q == '0))));
    assign newPix     = (state_q == FLUSH) ? '0 : in_pixel;

    // Frame control: input position tracking, flush sequencing, mode latch and output coordinates.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        inCol_d    = inCol_q;
        inRow_d    = inRow_q;
        outCol_d   = outCol_q;
        outRow_d   = outRow_q;
        flushCnt_d = flushCnt_q;
        lbPtr_d    = lbPtr_q;

        if (shift) begin
            lbPtr_d = (lbPtr_q == COL_LAST) ? '0 : lbPtr_q + 1'b1;
        end

        case (state_q)
            IDLE, ACTIVE: begin
                if (frameStart) begin
                    state_d  = ACTIVE;
                    mode_d   = mode_in;
                    inCol_d  = CW'(1);
                    inRow_d  = '0;
                    outCol_d = '0;
                    outRow_d = '0;
                end else if (xfer && (state_q == ACTIVE)) begin
                    if (inCol_q == COL_LAST) begin
                        inCol_d = '0;
                        if (inRow_q == ROW_LAST) begin
                            inRow_d    = '0;
                            flushCnt_d = '0;
                            state_d    = FLUSH;
                        end else begin
                            inRow_d = inRow_q + 1'b1;
                        end
                    end else begin
                        inCol_d = inCol_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (flushCnt_q == FLUSH_LAST) begin
                    flushCnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    flushCnt_d = flushCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (producing) begin
            if (outCol_q == COL_LAST) begin
                outCol_d = '0;
                outRow_d = (outRow_q == ROW_LAST) ? '0 : outRow_q + 1'b1;
            end else begin
                outCol_d = outCol_q + 1'b1;
            end
        end
    end

    // Control state register; the mode register defaults to the gaussian kernel.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= 2'b01;
            inCol_q    <= '0;
            inRow_q    <= '0;
            outCol_q   <= '0;
            outRow_q   <= '0;
            flushCnt_q <= '0;
            lbPtr_q    <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            inCol_q    <= inCol_d;
            inRow_q    <= inRow_d;
            outCol_q   <= outCol_d;
            outRow_q   <= outRow_d;
            flushCnt_q <= flushCnt_d;
            lbPtr_q    <= lbPtr_d;
        end
    end

    // Circular line buffers give one- and two-line delays; the window slides right by one column.
    always_ff @(posedge clk) begin
        if (shift) begin
            lineBuf1[lbPtr_q] <= newPix;
            lineBuf2[lbPtr_q] <= lineBuf1[lbPtr_q];
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= lineBuf2[lbPtr_q];
            win_q[1][2] <= lineBuf1[lbPtr_q];
            win_q[2][2] <= newPix;
        end
    end

    // Window-stage tag: centre coordinates and frame mode travel alongside the window contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q    <= 1'b0;
            c1_q    <= '0;
            r1_q    <= '0;
            mode1_q <= 2'b01;
        end else begin
            v1_q <= producing;
            if (producing) begin
                c1_q    <= outCol_q;
                r1_q    <= outRow_q;
                mode1_q <= mode_q;
            end
        end
    end

    // Border taps are forced to zero so wrapped columns and stale line-buffer rows never contribute.
    assign rowOk = {r1_q != ROW_LAST, 1'b1, r1_q != '0};
    assign colOk = {c1_q != COL_LAST, 1'b1, c1_q != '0};

    // Per-channel weighted sums; the kernel weights sum to 16 (or 4) so the shift cannot overflow.
    always_comb begin
        filtPix = '0;
        gSum    = '0;
        hSum    = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                tap[i][j] = '0;
            end
        end
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    tap[i][j] = (rowOk[i] && colOk[j]) ? win_q[i][j][ch*CH_W +: CH_W] : '0;
                end
            end
            gSum = GW'(tap[0][0])        + (GW'(tap[0][1]) << 1) + GW'(tap[0][2]) +
                   (GW'(tap[1][0]) << 1) + (GW'(tap[1][1]) << 2) + (GW'(tap[1][2]) << 1) +
                   GW'(tap[2][0])        + (GW'(tap[2][1]) << 1) + GW'(tap[2][2]);
            hSum = HW'(tap[1][0]) + (HW'(tap[1][1]) << 1) + HW'(tap[1][2]);
            case (mode1_q)
                2'b00:   filtPix[ch*CH_W +: CH_W] = win_q[1][1][ch*CH_W +: CH_W];
                2'b10:   filtPix[ch*CH_W +: CH_W] = hSum[HW-1:2];
                default: filtPix[ch*CH_W +: CH_W] = gSum[GW-1:4];
            endcase
        end
    end

    // Output stage next values; a restart drops the result of the abandoned frame still in flight.
    always_comb begin
        outValid_d = v1_q && !abortFrame;
        outSof_d   = outValid_d && (r1_q == '0) && (c1_q == '0);
        outEol_d   = outValid_d && (c1_q == COL_LAST);
        outPixel_d = outValid_d ? filtPix : outPixel_q;
    end

    // Output register; the pixel holds its last value between valid beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            outValid_q <= 1'b0;
            outSof_q   <= 1'b0;
            outEol_q   <= 1'b0;
            outPixel_q <= '0;
        end else begin
            outValid_q <= outValid_d;
            outSof_q   <= outSof_d;
            outEol_q   <= outEol_d;
            outPixel_q <= outPixel_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_sof   = outSof_q;
    assign out_eol   = outEol_q;
    assign out_pixel = outPixel_q;

endmodule
